// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared FIFO depth default and TX issue FSM state encoding
package uart_fifo_pkg;
  localparam int DEPTH_LOG2_DEFAULT = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, GUARD} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: 8-bit first-word-fall-through FIFO of depth 2**AW with occupancy level, full/empty evaluated at cycle start
module sync_fifo #(parameter int AW = 4) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [7:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level[AW];
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: CPU TX/RX FIFOs around a UART core; define UART_FIFO_OVERRUN_EN to drop RX bytes on full with sticky rx_overrun
module uart_fifo_bridge
  import uart_fifo_pkg::*;
#(parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_wr,
  input  logic [7:0]            tx_data,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_level,
  input  logic                  rx_rd,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic                  uart_wr,
  output logic [7:0]            uart_tx_data,
  input  logic                  uart_busy,
  output logic                  uart_rd,
  input  logic [7:0]            uart_rx_data,
`ifdef UART_FIFO_OVERRUN_EN
  output logic                  rx_overrun,
  input  logic                  rx_ovr_clr,
`endif
  input  logic                  uart_valid
);
  tx_state_e state, state_n;
  logic tx_empty, tx_pop, rx_empty, rx_full;
  logic [7:0] tx_head;
  sync_fifo #(.AW(DEPTH_LOG2)) u_tx (
    .clk(clk), .reset(reset), .push(tx_wr), .pop(tx_pop), .din(tx_data), .dout(tx_head),
    .full(tx_full), .empty(tx_empty), .level(tx_level)
  );
  assign tx_pop = state == IDLE && !tx_empty && !uart_busy;
  assign uart_wr = state == ISSUE;
  always_comb state_n = tx_pop ? ISSUE : state == ISSUE ? GUARD : IDLE;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) uart_tx_data <= '0;
    else if (tx_pop) uart_tx_data <= tx_head;
  end
`ifdef UART_FIFO_OVERRUN_EN
  assign uart_rd = uart_valid && !reset;
  always_ff @(posedge clk) begin
    if (reset) rx_overrun <= 1'b0;
    else rx_overrun <= (uart_valid && rx_full) || (rx_overrun && !rx_ovr_clr);
  end
`else
  assign uart_rd = uart_valid && !rx_full && !reset;
`endif
  assign rx_valid = !rx_empty;
  sync_fifo #(.AW(DEPTH_LOG2)) u_rx (
    .clk(clk), .reset(reset), .push(uart_rd), .pop(rx_rd), .din(uart_rx_data), .dout(rx_data),
    .full(rx_full), .empty(rx_empty), .level(rx_level)
  );
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: directed and random checks of uart_fifo_bridge against queue-based reference model
module tb_uart_fifo_bridge;
`ifdef UART_FIFO_OVERRUN_EN
  localparam bit OVR = 1'b1;
  logic rx_overrun, rx_ovr_clr;
`else
  localparam bit OVR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, tx_wr, tx_full, rx_rd, rx_valid, uart_wr, uart_busy, uart_rd, uart_valid;
  logic [7:0] tx_data, rx_data, uart_tx_data, uart_rx_data;
  logic [4:0] tx_level, rx_level;
  int checks = 0, errors = 0, cyc = 0, last_wr = -100, c0;
  logic [7:0] txq[$], rxq[$], ucore[$];
  int wr_cyc[$];
  bit ovr = 1'b0;
  always #5 clk = ~clk;
  uart_fifo_bridge dut (
    .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_level(tx_level),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_level(rx_level),
    .uart_wr(uart_wr), .uart_tx_data(uart_tx_data), .uart_busy(uart_busy), .uart_rd(uart_rd),
    .uart_rx_data(uart_rx_data),
`ifdef UART_FIFO_OVERRUN_EN
    .rx_overrun(rx_overrun), .rx_ovr_clr(rx_ovr_clr),
`endif
    .uart_valid(uart_valid)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    bit exp_rd, acc_tx, pop_rx, acc_rx, ovr_set, busy_at, rst_at, clr_at;
    logic [7:0] txd, rxd;
    uart_valid = ucore.size() > 0;
    uart_rx_data = uart_valid ? ucore[0] : 8'h00;
    #1;
    exp_rd = !reset && uart_valid && (OVR || rxq.size() < 16);
    chk("uart_rd", uart_rd, exp_rd);
    acc_tx = tx_wr && txq.size() < 16;
    pop_rx = rx_rd && rxq.size() > 0;
    acc_rx = uart_valid && rxq.size() < 16;
    ovr_set = uart_valid && rxq.size() == 16;
    busy_at = uart_busy;
    rst_at = reset;
    txd = tx_data;
    rxd = uart_rx_data;
`ifdef UART_FIFO_OVERRUN_EN
    clr_at = rx_ovr_clr;
`else
    clr_at = 1'b0;
`endif
    @(posedge clk);
    cyc++;
    if (rst_at) begin
      txq.delete();
      rxq.delete();
      ovr = 1'b0;
      last_wr = -100;
    end else begin
      if (acc_tx) txq.push_back(txd);
      if (pop_rx) void'(rxq.pop_front());
      if (acc_rx) rxq.push_back(rxd);
      if (exp_rd) void'(ucore.pop_front());
      ovr = ovr_set ? 1'b1 : clr_at ? 1'b0 : ovr;
    end
    #1;
    if (rst_at) chk("wr_after_reset", uart_wr, 1'b0);
    if (uart_wr) begin
      chk("wr_has_data", txq.size() != 0, 1'b1);
      if (txq.size() != 0) begin
        chk("uart_tx_data", uart_tx_data, txq[0]);
        void'(txq.pop_front());
      end
      chk("wr_gap", (cyc - last_wr) >= 3, 1'b1);
      chk("wr_while_busy", busy_at, 1'b0);
      last_wr = cyc;
      wr_cyc.push_back(cyc);
    end
    chk("tx_level", tx_level, txq.size());
    chk("tx_full", tx_full, txq.size() == 16);
    chk("rx_level", rx_level, rxq.size());
    chk("rx_valid", rx_valid, rxq.size() != 0);
    if (rxq.size() != 0) chk("rx_data", rx_data, rxq[0]);
`ifdef UART_FIFO_OVERRUN_EN
    chk("rx_overrun", rx_overrun, ovr);
`endif
  endtask
  initial begin
    reset = 1'b1; tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0; uart_busy = 1'b0;
    uart_valid = 1'b0; uart_rx_data = 8'h00;
`ifdef UART_FIFO_OVERRUN_EN
    rx_ovr_clr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_uart_wr", uart_wr, 1'b0);
    chk("rst_uart_tx_data", uart_tx_data, 8'h00);
    chk("rst_tx_full", tx_full, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_levels", {tx_level, rx_level}, 10'd0);
    reset = 1'b0;
    tx_wr = 1'b1; tx_data = 8'h55;
    tick();
    c0 = cyc;
    tx_data = 8'hA3;
    tick();
    tx_wr = 1'b0;
    repeat (6) tick();
    chk("t041_count", wr_cyc.size(), 2);
    if (wr_cyc.size() == 2) begin
      chk("t041_first", wr_cyc[0], c0 + 1);
      chk("t041_second", wr_cyc[1], c0 + 4);
    end
    wr_cyc.delete();
    uart_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tx_wr = 1'b1;
      tx_data = 8'($urandom);
      tick();
      if (i == 14) chk("t042_not_full15", tx_full, 1'b0);
      if (i == 15) chk("t042_full16", tx_full, 1'b1);
    end
    tx_wr = 1'b0;
    chk("t042_level", tx_level, 16);
    uart_busy = 1'b0;
    for (int i = 0; i < 80 && txq.size() > 0; i++) tick();
    repeat (3) tick();
    chk("t042_drained", txq.size(), 0);
    chk("t042_pulses", wr_cyc.size(), 16);
    ucore.push_back(8'h3C);
    tick();
    chk("t043_rx_valid", rx_valid, 1'b1);
    chk("t043_rx_data", rx_data, 8'h3C);
    chk("t043_rx_level", rx_level, 1);
    for (int i = 0; i < 16; i++) ucore.push_back(8'($urandom));
    repeat (16) tick();
    chk("t044_level", rx_level, 16);
`ifdef UART_FIFO_OVERRUN_EN
    chk("t044_ovr_set", rx_overrun, 1'b1);
    tick();
    chk("t044_ovr_sticky", rx_overrun, 1'b1);
    rx_ovr_clr = 1'b1;
    tick();
    rx_ovr_clr = 1'b0;
    chk("t044_ovr_clr", rx_overrun, 1'b0);
`else
    uart_valid = ucore.size() > 0;
    #1;
    chk("t044_rd_blocked", uart_rd, 1'b0);
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
    chk("t044_full_start", rx_level, 15);
    tick();
    chk("t044_accept_next", rx_level, 16);
`endif
    rx_rd = 1'b1;
    for (int i = 0; i < 20 && rxq.size() > 5; i++) tick();
    rx_rd = 1'b0;
    chk("t045_level5", rx_level, 5);
    for (int i = 0; i < 24; i++) begin
      ucore.push_back(8'($urandom));
      rx_rd = 1'b1;
      tick();
      chk("t045_level_steady", rx_level, 5);
    end
    rx_rd = 1'b0;
    uart_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_wr = 1'b1;
      tx_data = 8'($urandom);
      tick();
    end
    tx_wr = 1'b0;
    uart_busy = 1'b0;
    for (int i = 0; i < 5 && !uart_wr; i++) tick();
    chk("t046_in_issue", uart_wr, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t046_wr", uart_wr, 1'b0);
    chk("t046_tx_data", uart_tx_data, 8'h00);
    chk("t046_levels", {tx_level, rx_level}, 10'd0);
    chk("t046_rx_valid", rx_valid, 1'b0);
    repeat (4) tick();
    for (int i = 0; i < 1500; i++) begin
      tx_wr = $urandom_range(0, 2) == 0;
      tx_data = 8'($urandom);
      uart_busy = $urandom_range(0, 3) == 0;
      rx_rd = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 1) == 0 && ucore.size() < 4) ucore.push_back(8'($urandom));
`ifdef UART_FIFO_OVERRUN_EN
      rx_ovr_clr = $urandom_range(0, 7) == 0;
`endif
      tick();
    end
    tx_wr = 1'b0; uart_busy = 1'b0; rx_rd = 1'b1;
`ifdef UART_FIFO_OVERRUN_EN
    rx_ovr_clr = 1'b0;
`endif
    for (int i = 0; i < 120 && (txq.size() + rxq.size() + ucore.size()) > 0; i++) tick();
    chk("final_drain", txq.size() + rxq.size() + ucore.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_fifo_bridge.md
UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, log2 of each FIFO depth (depth 16).
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 tx_wr  in  1  CPU push strobe for TX FIFO.
REQ-005 tx_data  in  8  byte to push.
REQ-006 tx_full  out  1  TX FIFO full.
REQ-007 tx_level  out  DEPTH_LOG2+1  TX FIFO occupancy.
REQ-008 rx_rd  in  1  CPU pop strobe for RX FIFO.
REQ-009 rx_data  out  8  RX FIFO head byte, first-word-fall-through.
REQ-010 rx_valid  out  1  RX FIFO non-empty.
REQ-011 rx_level  out  DEPTH_LOG2+1  RX FIFO occupancy.
REQ-012 uart_wr  out  1  transmit strobe to UART core.
REQ-013 uart_tx_data  out  8  byte to UART core.
REQ-014 uart_busy  in  1  UART transmitter busy.
REQ-015 uart_rd  out  1  acknowledge to UART core, clears its received byte.
REQ-016 uart_rx_data  in  8  UART received byte.
REQ-017 uart_valid  in  1  UART holds an unread byte.
REQ-018 rx_overrun  out  1  sticky drop flag (present only with macro, REQ-037).
REQ-019 rx_ovr_clr  in  1  clears rx_overrun (present only with macro).

Function
REQ-020 TX push when tx_wr && !tx_full; tx_wr while full ignored, contents unchanged.
REQ-021 TX issue FSM states IDLE, ISSUE, GUARD, encoded as a package enum.
REQ-022 IDLE -> ISSUE when TX FIFO non-empty && !uart_busy; head popped and registered into uart_tx_data on that edge.
REQ-023 ISSUE lasts exactly one cycle with uart_wr=1; uart_wr is decoded from state, never high outside ISSUE.
REQ-024 ISSUE -> GUARD unconditionally; GUARD -> IDLE unconditionally, covering UART busy-rise latency.
REQ-025 Back-to-back bytes: minimum 3 cycles between uart_wr pulses; otherwise paced by uart_busy.
REQ-026 uart_tx_data holds its value after ISSUE until the next pop.
REQ-027 RX: uart_rd = uart_valid && !rx_full (combinational); push uart_rx_data in the same cycle.
REQ-028 RX pop when rx_rd && rx_valid; rx_rd while empty ignored.
REQ-029 Simultaneous push and pop on either FIFO: level unchanged, both operations performed.
REQ-030 Full is evaluated at cycle start: RX full plus rx_rd in the same cycle does not accept a UART byte that cycle.
REQ-031 Pointers DEPTH_LOG2 bits, wrap modulo depth; level = write count minus read count, never exceeds depth.

Reset
REQ-032 Reset clears both FIFO pointers and levels to 0 and sets FSM to IDLE.
REQ-033 Reset values: uart_wr=0, uart_tx_data=0, tx_full=0, rx_valid=0, rx_overrun=0; rx_data is don't-care while rx_valid=0.
REQ-034 uart_rd is forced 0 during reset.
REQ-035 Reset mid-operation aborts the FSM; a byte already handed to the UART core completes under the core's own control; queued bytes are discarded.

Configuration
REQ-036 Macro UART_FIFO_OVERRUN_EN.
REQ-037 Defined: uart_rd = uart_valid always; when RX is full the byte is dropped and rx_overrun set, cleared by rx_ovr_clr (set wins on the same cycle); ports REQ-018/019 exist.
REQ-038 Undefined: backpressure per REQ-027; the byte is left in the UART core; REQ-018/019 ports are absent.

Structure
REQ-039 Package uart_fifo_pkg holds the FSM state enum and the DEPTH_LOG2 default constant.
REQ-040 Sub-module sync_fifo (8-bit, parameterised depth, FWFT, push/pop/full/empty/level) is instantiated twice.

Verification
REQ-041 Push 0x55, 0xA3 with uart_busy=0 -> uart_wr pulses carry 0x55 then 0xA3, each exactly 1 cycle, no tx_wr lost.
REQ-042 Push 17 bytes back-to-back with uart_busy=1 -> tx_full after 16, 17th ignored, tx_level=16.
REQ-043 uart_valid=1 with 0x3C -> uart_rd high same cycle, next cycle rx_valid=1, rx_data=0x3C, rx_level=1.
REQ-044 RX full plus uart_valid: without macro uart_rd=0 and level stays 16; with macro byte dropped, rx_overrun=1 until rx_ovr_clr.
REQ-045 Simultaneous rx_rd and UART push at level 5 -> level stays 5, order preserved across pointer wrap.
REQ-046 Reset asserted in ISSUE -> next cycle uart_wr=0, FSM IDLE, levels 0.
